exu_alu_issue: RTL and testbench
================================

// Module: exu_alu_issue
// PURPOSE
//   Initiator side of the execute-stage ALU handshake. Accepts one decoded op from ID (valid/ready),
//   selects and latches operands, pulses alu_valid to the ALU, waits for alu_data_ok, captures the
//   result and holds it for writeback (valid/ready). Sits between the decode pipeline register and
//   the ALU, and owns the ALU A/B/op inputs. Single op in flight.
// PARAMETERS
//   ALUOP_WIDTH  5   width of ALU opcode field (op passed through unmodified)
//   TIMEOUT_CYC  15  max WAIT cycles before abandoning op with error; 0 = never time out
// PORTS
//   clk          in   1   single clock, all logic rising-edge
//   rst_n        in   1   synchronous reset, active-low
//   flush        in   1   pipeline flush: abandon in-flight op
//   id_valid     in   1   decode presents an op
//   id_ready     out  1   block can accept an op this cycle
//   id_aluop     in   ALUOP_WIDTH  ALU operation code
//   id_rs1_val   in   64  rs1 operand
//   id_rs2_val   in   64  rs2 operand
//   id_imm       in   64  sign-extended immediate
//   id_pc        in   64  instruction PC
//   id_src_a_pc  in   1   1: A=id_pc, 0: A=id_rs1_val
//   id_src_b_imm in   1   1: B=id_imm, 0: B=id_rs2_val
//   id_rd        in   5   destination register index
//   id_wen       in   1   op writes rd
//   alu_valid    out  1   request to ALU (exu_valid side)
//   alu_a        out  64  latched operand A
//   alu_b        out  64  latched operand B
//   alu_op       out  ALUOP_WIDTH  latched opcode
//   alu_data     in   64  ALU result (combinational from alu_a/alu_b/alu_op)
//   alu_data_ok  in   1   ALU result-ready, registered by ALU one cycle after alu_valid
//   wb_valid     out  1   result held for writeback
//   wb_ready     in   1   writeback consumes result
//   wb_data      out  64  captured result (0 on timeout)
//   wb_rd        out  5   latched rd
//   wb_wen       out  1   latched wen (forced 0 on timeout)
//   wb_err       out  1   op timed out
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE; alu_valid, wb_valid, wb_err, wb_wen, busy = 0;
//     alu_a, alu_b, wb_data = 0; alu_op, wb_rd = 0; timeout counter = 0.
//   States IDLE, ISSUE, WAIT, RESP.
//   id_ready = !flush && (IDLE || (RESP && wb_ready)); combinational from wb_ready/flush, no other path.
//   Accept = id_valid && id_ready: latch A/B by src selects, op, rd, wen; next state ISSUE.
//   ISSUE: alu_valid=1 for exactly one cycle; alu_data_ok seen here is stale, ignored; -> WAIT.
//   WAIT: alu_valid=0; alu_a/b/op held stable. On alu_data_ok: wb_data<=alu_data, wb_err<=0, -> RESP.
//     Else counter++; if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: wb_data<=0, wb_wen<=0,
//     wb_err<=1, -> RESP. Counter cleared on entry to WAIT.
//   RESP: wb_valid=1, wb_* stable until wb_ready. wb_ready && !id_valid -> IDLE;
//     wb_ready && id_valid -> accept new op, -> ISSUE (back-to-back).
//   Latency: accept edge T; alu_valid cycle T+1; alu_data_ok cycle T+2; wb_valid from T+3.
//     Min throughput one op per 3 cycles.
//   IDLE/RESP: alu_data_ok ignored.
//   flush (priority over everything but reset): next state IDLE, wb_valid=0 and alu_valid=0
//     next cycle, no accept in flush cycle; stale alu_data_ok after flush lands in IDLE, ignored.
//   Width: all datapath 64 bit; no arithmetic beyond mux; counter wide enough for TIMEOUT_CYC.
// TESTING
//   1 ADD: A=5,B=7,op=0,rd=3,wen=1; ALU model data_ok 1 cycle after valid -> alu_valid 1 cyc at T+1,
//     wb_valid at T+3, wb_data=12, wb_rd=3, wb_wen=1, wb_err=0.
//   2 Src select: src_a_pc=1 pc=0x8000_0000, src_b_imm=1 imm=0xFFFF_FFFF_FFFF_FFFC
//     -> alu_a=0x8000_0000, alu_b=imm; rs1/rs2 changes after accept do not affect alu_a/b.
//   3 Backpressure: wb_ready=0 for 5 cycles -> wb_* constant, id_ready=0; wb_ready=1 with id_valid=1
//     -> same-cycle accept, next alu_valid pulse one cycle later.
//   4 Timeout: ALU never asserts data_ok, TIMEOUT_CYC=15 -> wb_valid after 15 WAIT cycles,
//     wb_err=1, wb_data=0, wb_wen=0.
//   5 Flush in ISSUE: next cycle state IDLE, data_ok arriving then ignored, no wb_valid;
//     next op gives correct result.
//   6 Reset mid-WAIT: rst_n=0 one edge -> all outputs at reset values, busy=0, id_ready=1.

Source files
------------

// File: rtl/exu_alu_issue.sv
// rtl/exu_alu_issue.sv - execute-stage ALU issue/response handshake, single op in flight
module exu_alu_issue #(
    parameter int ALUOP_WIDTH = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [ALUOP_WIDTH-1:0] id_aluop,
    input  logic [63:0]            id_rs1_val,
    input  logic [63:0]            id_rs2_val,
    input  logic [63:0]            id_imm,
    input  logic [63:0]            id_pc,
    input  logic                   id_src_a_pc,
    input  logic                   id_src_b_imm,
    input  logic [4:0]             id_rd,
    input  logic                   id_wen,
    output logic                   alu_valid,
    output logic [63:0]            alu_a,
    output logic [63:0]            alu_b,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    input  logic [63:0]            alu_data,
    input  logic                   alu_data_ok,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [63:0]            wb_data,
    output logic [4:0]             wb_rd,
    output logic                   wb_wen,
    output logic                   wb_err,
    output logic                   busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             data_done;
    logic             timed_out;

    assign id_ready  = !flush && ((state == S_IDLE) || ((state == S_RESP) && wb_ready));
    assign accept    = id_valid && id_ready;
    assign data_done = (state == S_WAIT) && alu_data_ok;
    // A result arriving on the last allowed cycle still wins over the timeout.
    assign timed_out = (state == S_WAIT) && !alu_data_ok && (TIMEOUT_CYC != 0)
                       && (wait_cnt == CNT_LAST);

    assign alu_valid = (state == S_ISSUE);
    assign wb_valid  = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_nxt = S_ISSUE;
                S_ISSUE: state_nxt = S_WAIT;
                S_WAIT:  if (data_done || timed_out) state_nxt = S_RESP;
                S_RESP:  if (wb_ready) state_nxt = accept ? S_ISSUE : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_wen   <= 1'b0;
            wb_err   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                alu_a  <= id_src_a_pc  ? id_pc  : id_rs1_val;
                alu_b  <= id_src_b_imm ? id_imm : id_rs2_val;
                alu_op <= id_aluop;
                wb_rd  <= id_rd;
                wb_wen <= id_wen;
            end

            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (!flush) begin
                if (data_done) begin
                    wb_data <= alu_data;
                    wb_err  <= 1'b0;
                end else if (timed_out) begin
                    wb_data <= '0;
                    wb_wen  <= 1'b0;
                    wb_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exu_alu_issue.sv
// tb/tb_exu_alu_issue.sv - self-checking bench for exu_alu_issue with a behavioural ALU responder
module tb_exu_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [4:0]  id_aluop = '0;
    logic [63:0] id_rs1_val = '0;
    logic [63:0] id_rs2_val = '0;
    logic [63:0] id_imm = '0;
    logic [63:0] id_pc = '0;
    logic        id_src_a_pc = 1'b0;
    logic        id_src_b_imm = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_wen = 1'b0;
    logic        alu_valid;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_data;
    logic        alu_data_ok = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic        wb_err;
    logic        busy;
    logic        alu_en = 1'b1;

    int passed = 0;
    int total = 0;

    exu_alu_issue #(.ALUOP_WIDTH(5), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_aluop(id_aluop),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_pc(id_pc),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .id_rd(id_rd), .id_wen(id_wen),
        .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_data(alu_data), .alu_data_ok(alu_data_ok),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_wen(wb_wen), .wb_err(wb_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [1:0] sel;
        sel = op[1:0];
        case (sel)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a | b;
        endcase
    endfunction

    // ALU: combinational result, data_ok registered one cycle after alu_valid
    assign alu_data = alu_fn(alu_op, alu_a, alu_b);
    always @(posedge clk) alu_data_ok <= alu_en && alu_valid;

    task automatic drive_op(input logic [4:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                            input logic [63:0] imm, input logic [63:0] pc, input logic sa,
                            input logic sb, input logic [4:0] rd, input logic wen);
        id_aluop = op; id_rs1_val = rs1; id_rs2_val = rs2; id_imm = imm; id_pc = pc;
        id_src_a_pc = sa; id_src_b_imm = sb; id_rd = rd; id_wen = wen; id_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy, alu_valid, wb_valid, wb_err, wb_wen} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {busy, alu_valid, wb_valid, wb_err, wb_wen}); else passed++;
        total++; if ({alu_a, alu_b, wb_data, alu_op, wb_rd} !== '0) $display("FAIL reset_data got %h/%h/%h exp 0", alu_a, alu_b, wb_data); else passed++;
        total++; if (id_ready !== 1'b1) $display("FAIL reset_id_ready got %b exp 1", id_ready); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        drive_op(5'd0, 64'd5, 64'd7, 64'd0, 64'd0, 1'b0, 1'b0, 5'd3, 1'b1);
        #1;
        total++; if (id_ready !== 1'b1) $display("FAIL add_id_ready got %b exp 1", id_ready); else passed++;
        @(negedge clk); id_valid = 1'b0;
        total++; if ({alu_valid, wb_valid} !== 2'b10) $display("FAIL add_t1_valids got %b exp 10", {alu_valid, wb_valid}); else passed++;
        total++; if ({alu_a, alu_b, alu_op} !== {64'd5, 64'd7, 5'd0}) $display("FAIL add_operands got a=%0d b=%0d op=%0d exp 5 7 0", alu_a, alu_b, alu_op); else passed++;
        @(negedge clk);
        total++; if ({alu_valid, wb_valid, busy} !== 3'b001) $display("FAIL add_t2_flags got %b exp 001", {alu_valid, wb_valid, busy}); else passed++;
        @(negedge clk);
        total++; if (wb_valid !== 1'b1) $display("FAIL add_t3_wb_valid got %b exp 1", wb_valid); else passed++;
        total++; if (wb_data !== 64'd12) $display("FAIL add_wb_data got %0d exp 12", wb_data); else passed++;
        total++; if ({wb_rd, wb_wen, wb_err} !== {5'd3, 1'b1, 1'b0}) $display("FAIL add_wb_meta got rd=%0d wen=%b err=%b exp 3 1 0", wb_rd, wb_wen, wb_err); else passed++;
        wb_ready = 1'b1;
        @(negedge clk); wb_ready = 1'b0;
        total++; if ({busy, wb_valid} !== 2'b00) $display("FAIL add_release got %b exp 00", {busy, wb_valid}); else passed++;
    endtask

    task automatic test_src_select();
        logic [63:0] exp_a, exp_b;
        exp_a = 64'h0000_0000_8000_0000;
        exp_b = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        drive_op(5'd2, {$urandom, $urandom}, {$urandom, $urandom}, exp_b, exp_a, 1'b1, 1'b1, 5'd9, 1'b1);
        @(negedge clk);
        id_valid = 1'b0; id_rs1_val = {$urandom, $urandom}; id_rs2_val = {$urandom, $urandom};
        id_pc = 64'd0; id_imm = 64'd0; id_src_a_pc = 1'b0; id_src_b_imm = 1'b0;
        total++; if ({alu_a, alu_b} !== {exp_a, exp_b}) $display("FAIL src_sel_issue got a=%h b=%h exp a=%h b=%h", alu_a, alu_b, exp_a, exp_b); else passed++;
        @(negedge clk);
        total++; if ({alu_a, alu_b} !== {exp_a, exp_b}) $display("FAIL src_sel_hold got a=%h b=%h exp a=%h b=%h", alu_a, alu_b, exp_a, exp_b); else passed++;
        @(negedge clk);
        total++; if ({wb_valid, wb_data} !== {1'b1, exp_a ^ exp_b}) $display("FAIL src_sel_result got v=%b d=%h exp 1 %h", wb_valid, wb_data, exp_a ^ exp_b); else passed++;
        wb_ready = 1'b1;
        @(negedge clk); wb_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] a1, b1, a2, b2;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        @(negedge clk);
        drive_op(5'd1, a1, b1, 64'd0, 64'd0, 1'b0, 1'b0, 5'd4, 1'b1);
        @(negedge clk); id_valid = 1'b0;
        repeat (2) @(negedge clk);
        drive_op(5'd3, a2, b2, 64'd0, 64'd0, 1'b0, 1'b0, 5'd17, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if ({id_ready, wb_valid, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd4, a1 - b1}) $display("FAIL bp_hold_%0d got rdy=%b v=%b rd=%0d d=%h exp 0 1 4 %h", i, id_ready, wb_valid, wb_rd, wb_data, a1 - b1); else passed++;
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        total++; if (id_ready !== 1'b1) $display("FAIL bp_same_cycle_ready got %b exp 1", id_ready); else passed++;
        @(negedge clk); wb_ready = 1'b0; id_valid = 1'b0;
        total++; if ({alu_valid, wb_valid, alu_a, alu_b} !== {1'b1, 1'b0, a2, b2}) $display("FAIL bp_next_issue got av=%b wv=%b a=%h b=%h", alu_valid, wb_valid, alu_a, alu_b); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({wb_valid, wb_data, wb_rd, wb_wen} !== {1'b1, a2 | b2, 5'd17, 1'b0}) $display("FAIL bp_second_result got v=%b d=%h rd=%0d wen=%b exp 1 %h 17 0", wb_valid, wb_data, wb_rd, wb_wen, a2 | b2); else passed++;
        wb_ready = 1'b1;
        @(negedge clk); wb_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc;
        alu_en = 1'b0;
        @(negedge clk);
        drive_op(5'd0, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 1'b0, 5'd21, 1'b1);
        @(negedge clk); id_valid = 1'b0;
        cyc = 1;
        while (!wb_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc !== 17) $display("FAIL timeout_latency got %0d cycles exp 17", cyc); else passed++;
        total++; if ({wb_err, wb_wen, wb_data, wb_rd} !== {1'b1, 1'b0, 64'd0, 5'd21}) $display("FAIL timeout_wb got err=%b wen=%b d=%h rd=%0d exp 1 0 0 21", wb_err, wb_wen, wb_data, wb_rd); else passed++;
        wb_ready = 1'b1;
        @(negedge clk); wb_ready = 1'b0;
        alu_en = 1'b1;
    endtask

    task automatic test_flush();
        logic [63:0] a, b;
        int cyc;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        @(negedge clk);
        drive_op(5'd0, 64'd40, 64'd2, 64'd0, 64'd0, 1'b0, 1'b0, 5'd6, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        drive_op(5'd2, a, b, 64'd0, 64'd0, 1'b0, 1'b0, 5'd7, 1'b1);
        #1;
        total++; if (id_ready !== 1'b0) $display("FAIL flush_id_ready got %b exp 0", id_ready); else passed++;
        @(negedge clk); flush = 1'b0; id_valid = 1'b0;
        total++; if ({busy, alu_valid, wb_valid} !== 3'b000) $display("FAIL flush_idle got %b exp 000", {busy, alu_valid, wb_valid}); else passed++;
        @(negedge clk);
        total++; if ({busy, wb_valid} !== 2'b00) $display("FAIL flush_stale_ok got %b exp 00", {busy, wb_valid}); else passed++;
        drive_op(5'd2, a, b, 64'd0, 64'd0, 1'b0, 1'b0, 5'd7, 1'b1);
        @(negedge clk); id_valid = 1'b0;
        cyc = 1;
        while (!wb_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        total++; if ({wb_valid, wb_data, wb_rd, wb_err} !== {1'b1, a ^ b, 5'd7, 1'b0}) $display("FAIL flush_next_op got v=%b d=%h rd=%0d err=%b exp 1 %h 7 0", wb_valid, wb_data, wb_rd, wb_err, a ^ b); else passed++;
        wb_ready = 1'b1;
        @(negedge clk); wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        alu_en = 1'b0;
        @(negedge clk);
        drive_op(5'd0, 64'd3, 64'd4, 64'd0, 64'd0, 1'b0, 1'b0, 5'd30, 1'b1);
        @(negedge clk); id_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({busy, alu_valid, wb_valid, wb_err, wb_wen, id_ready} !== 6'b000001) $display("FAIL rst_wait_flags got %b exp 000001", {busy, alu_valid, wb_valid, wb_err, wb_wen, id_ready}); else passed++;
        total++; if ({alu_a, alu_b, wb_data, alu_op, wb_rd} !== '0) $display("FAIL rst_wait_data got a=%h b=%h d=%h rd=%0d exp 0", alu_a, alu_b, wb_data, wb_rd); else passed++;
        rst_n = 1'b1;
        alu_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  op, rd;
        logic [63:0] rs1, rs2, imm, pc, exp_a, exp_b;
        logic        sa, sb, wen, pending;
        pending = 1'b0;
        for (int i = 0; i < 25; i++) begin
            op = 5'($urandom); rd = 5'($urandom); wen = 1'($urandom);
            sa = 1'($urandom); sb = 1'($urandom);
            rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
            imm = {$urandom, $urandom}; pc = {$urandom, $urandom};
            exp_a = sa ? pc : rs1;
            exp_b = sb ? imm : rs2;
            drive_op(op, rs1, rs2, imm, pc, sa, sb, rd, wen);
            wb_ready = pending;
            #1;
            total++; if (id_ready !== 1'b1) $display("FAIL b2b_%0d_id_ready got %b exp 1", i, id_ready); else passed++;
            @(negedge clk); id_valid = 1'b0; wb_ready = 1'b0;
            total++; if ({alu_valid, alu_a, alu_b, alu_op} !== {1'b1, exp_a, exp_b, op}) $display("FAIL b2b_%0d_issue got v=%b a=%h b=%h op=%0d", i, alu_valid, alu_a, alu_b, alu_op); else passed++;
            repeat (2) @(negedge clk);
            total++; if ({wb_valid, wb_data, wb_rd, wb_wen, wb_err} !== {1'b1, alu_fn(op, exp_a, exp_b), rd, wen, 1'b0}) $display("FAIL b2b_%0d_result got v=%b d=%h rd=%0d wen=%b err=%b exp d=%h", i, wb_valid, wb_data, wb_rd, wb_wen, wb_err, alu_fn(op, exp_a, exp_b)); else passed++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pending = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                wb_ready = 1'b1;
                @(negedge clk); wb_ready = 1'b0;
                total++; if ({busy, wb_valid} !== 2'b00) $display("FAIL b2b_%0d_drain got %b exp 00", i, {busy, wb_valid}); else passed++;
                pending = 1'b0;
            end
        end
        wb_ready = 1'b1;
        @(negedge clk); wb_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_src_select();
        test_backpressure();
        test_timeout();
        test_flush();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
